vga_video_timing: RTL and testbench

//  Free-running VGA raster timing generator in the clk_pixel domain. Drives the

---
 rtl/vga_video_timing.sv | 92 +++++++++
 tb/tb_vga_video_timing.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vga_video_timing.sv
// vga_video_timing: free-running VGA raster counters with sync/blank decode and a ce-gated realignment delay line
module vga_video_timing #(
    parameter int   H_VISIBLE  = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_VISIBLE  = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   SYNC_DELAY = 0,
    parameter int   XY_BITS    = 10
) (
    input  logic               i_clk_pixel,
    input  logic               i_rst_n,
    input  logic               i_ce,
    output logic [XY_BITS-1:0] o_x,
    output logic [XY_BITS-1:0] o_y,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_blank
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int CW      = XY_BITS + 1;
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS   = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS   = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_END  = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_END  = CW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [2:0]    RST_DEC = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    if (H_TOTAL > 2**XY_BITS || V_TOTAL > 2**XY_BITS) begin : g_bad_xy
        $error("vga_video_timing: XY_BITS=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d", XY_BITS, H_TOTAL - 1, V_TOTAL - 1);
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_delay
        $error("vga_video_timing: SYNC_DELAY=%0d outside 0..15", SYNC_DELAY);
    end

    logic               w_x_end;
    logic [XY_BITS-1:0] w_x_nxt;
    logic [XY_BITS-1:0] w_y_nxt;
    logic [CW-1:0]      w_xe;
    logic [CW-1:0]      w_ye;
    logic [2:0]         w_dec;
    logic [2:0]         r_dl [SYNC_DELAY+1];

    // Decode from the next-state position so the registered decode lines up with o_x/o_y.
    always_comb begin
        w_x_end = {1'b0, o_x} == H_LAST;
        w_x_nxt = w_x_end ? '0 : o_x + 1'b1;
        w_y_nxt = !w_x_end ? o_y : ({1'b0, o_y} == V_LAST) ? '0 : o_y + 1'b1;
        w_xe    = {1'b0, w_x_nxt};
        w_ye    = {1'b0, w_y_nxt};
        w_dec   = {(w_xe >= HS_BEG && w_xe < HS_END) ? HSYNC_POL : ~HSYNC_POL,
                   (w_ye >= VS_BEG && w_ye < VS_END) ? VSYNC_POL : ~VSYNC_POL,
                   w_xe >= H_VIS || w_ye >= V_VIS};
    end

    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b1;
            o_frame_start <= 1'b1;
        end else if (i_ce) begin
            o_x           <= w_x_nxt;
            o_y           <= w_y_nxt;
            o_line_start  <= w_x_nxt == '0;
            o_frame_start <= w_x_nxt == '0 && w_y_nxt == '0;
        end
    end

    // Stage 0 is aligned with x/y; each further stage adds one ce-qualified cycle.
    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i <= SYNC_DELAY; i++) r_dl[i] <= RST_DEC;
        end else if (i_ce) begin
            r_dl[0] <= w_dec;
            for (int i = 1; i <= SYNC_DELAY; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    assign {o_hsync, o_vsync, o_blank} = r_dl[SYNC_DELAY];
endmodule

// File: tb/tb_vga_video_timing.sv
// tb_vga_video_timing: directed checks of 640x480 line timing, delayed sync, ce freeze, async reset, and small-raster frames
module tb_vga_video_timing;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce = 1'b0;
    logic [9:0] a_x, a_y, d_x, d_y;
    logic       a_ls, a_fs, a_hs, a_vs, a_bl;
    logic       d_ls, d_fs, d_hs, d_vs, d_bl;
    logic [4:0] s_x, s_y;
    logic       s_ls, s_fs, s_hs, s_vs, s_bl;
    int n_vec = 0, n_bad = 0;
    int ax = 0, ay = 0, sx = 0, sy = 0;

    always #5 clk = ~clk;

    vga_video_timing u_a (
        .i_clk_pixel(clk), .i_rst_n(rst_n), .i_ce(ce), .o_x(a_x), .o_y(a_y),
        .o_line_start(a_ls), .o_frame_start(a_fs), .o_hsync(a_hs), .o_vsync(a_vs), .o_blank(a_bl)
    );

    vga_video_timing #(.SYNC_DELAY(3)) u_d (
        .i_clk_pixel(clk), .i_rst_n(rst_n), .i_ce(ce), .o_x(d_x), .o_y(d_y),
        .o_line_start(d_ls), .o_frame_start(d_fs), .o_hsync(d_hs), .o_vsync(d_vs), .o_blank(d_bl)
    );

    // 16x13 raster: hsync active-high on x=10..12, vsync active-low on y=8..9
    vga_video_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .XY_BITS(5)
    ) u_s (
        .i_clk_pixel(clk), .i_rst_n(rst_n), .i_ce(ce), .o_x(s_x), .o_y(s_y),
        .o_line_start(s_ls), .o_frame_start(s_fs), .o_hsync(s_hs), .o_vsync(s_vs), .o_blank(s_bl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        if (ce) begin
            if (ax == 799) begin ax = 0; ay = (ay == 524) ? 0 : ay + 1; end else ax++;
            if (sx == 15) begin sx = 0; sy = (sy == 12) ? 0 : sy + 1; end else sx++;
        end
    endtask

    int   perr = 0, a_fs_n = 0, a_ls_n = 0, hs_n = 0, hs_lo = -1, hs_hi = -1, bl_n = 0, bl_lo = -1;
    int   d_hs_fall = -1, d_bl_rise = -1;
    logic d_hs_p = 1'b1, d_bl_p = 1'b0;
    int   s_perr = 0, s_fs_n = 0, s_ls_n = 0, s_vs_n = 0, s_vs_lo = -1, s_vs_hi = -1;
    int   s_hs_n = 0, s_hs_lo = -1, s_hs_hi = -1, s_bl_n = 0;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_x", a_x, 0);
        chk("rst_y", a_y, 0);
        chk("rst_ls", a_ls, 1);
        chk("rst_fs", a_fs, 1);
        chk("rst_hs", a_hs, 1);
        chk("rst_vs", a_vs, 1);
        chk("rst_bl", a_bl, 0);
        chk("rst_d_hs", d_hs, 1);
        chk("rst_s_hs", s_hs, 0);
        chk("rst_s_vs", s_vs, 1);
        step;
        rst_n = 1'b1;
        step;
        chk("hold_x", a_x, 0);
        chk("hold_fs", a_fs, 1);
        ce = 1'b1;
        for (int i = 0; i < 832; i++) begin
            perr += int'(a_x !== ax || a_y !== ay || d_x !== ax || d_y !== ay || a_vs !== 1'b1 ||
                          a_ls !== (ax == 0) || a_fs !== (ax == 0 && ay == 0));
            a_fs_n += int'(a_fs);
            a_ls_n += int'(a_ls);
            if (ay == 0) begin
                if (a_hs == 1'b0) begin hs_n++; if (hs_lo < 0) hs_lo = ax; hs_hi = ax; end
                if (a_bl) begin bl_n++; if (bl_lo < 0) bl_lo = ax; end
                if (d_hs_p && !d_hs && d_hs_fall < 0) d_hs_fall = ax;
                if (!d_bl_p && d_bl && d_bl_rise < 0) d_bl_rise = ax;
            end
            d_hs_p = d_hs;
            d_bl_p = d_bl;
            s_perr += int'(s_x !== sx || s_y !== sy || s_ls !== (sx == 0) || s_fs !== (sx == 0 && sy == 0));
            s_fs_n += int'(s_fs);
            s_ls_n += int'(s_ls);
            s_bl_n += int'(s_bl);
            if (s_vs == 1'b0) begin s_vs_n++; if (s_vs_lo < 0) s_vs_lo = sy; s_vs_hi = sy; end
            if (s_hs == 1'b1) begin s_hs_n++; if (s_hs_lo < 0 || sx < s_hs_lo) s_hs_lo = sx; if (sx > s_hs_hi) s_hs_hi = sx; end
            step;
        end
        chk("pos_err", perr, 0);
        chk("fs_count", a_fs_n, 1);
        chk("ls_count", a_ls_n, 2);
        chk("hs_cycles", hs_n, 96);
        chk("hs_first", hs_lo, 656);
        chk("hs_last", hs_hi, 751);
        chk("bl_cycles", bl_n, 160);
        chk("bl_first", bl_lo, 640);
        chk("d3_hs_fall", d_hs_fall, 659);
        chk("d3_bl_rise", d_bl_rise, 643);
        chk("s_pos_err", s_perr, 0);
        chk("s_fs_count", s_fs_n, 4);
        chk("s_ls_count", s_ls_n, 52);
        chk("s_vs_cycles", s_vs_n, 128);
        chk("s_vs_first", s_vs_lo, 8);
        chk("s_vs_last", s_vs_hi, 9);
        chk("s_hs_cycles", s_hs_n, 156);
        chk("s_hs_xlo", s_hs_lo, 10);
        chk("s_hs_xhi", s_hs_hi, 12);
        chk("s_bl_cycles", s_bl_n, 640);
        chk("wrap_x", a_x, 32);
        chk("wrap_y", a_y, 1);
        chk("s_wrap_fs", s_fs, 1);
        repeat (623) step;
        chk("ce_x0", a_x, 655);
        chk("ce_hs0", a_hs, 1);
        ce = 1'b0;
        step;
        chk("ce_hold1_x", a_x, 655);
        chk("ce_hold1_hs", a_hs, 1);
        step;
        chk("ce_hold2_x", a_x, 655);
        chk("ce_hold2_hs", a_hs, 1);
        ce = 1'b1;
        step;
        chk("ce_x1", a_x, 656);
        chk("ce_hs1", a_hs, 0);
        chk("ce_s_x", s_x, sx);
        chk("ce_s_y", s_y, sy);
        repeat (44) step;
        chk("pre_rst_x", a_x, 700);
        chk("pre_rst_bl", a_bl, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", a_x, 0);
        chk("arst_y", a_y, 0);
        chk("arst_ls", a_ls, 1);
        chk("arst_fs", a_fs, 1);
        chk("arst_hs", a_hs, 1);
        chk("arst_bl", a_bl, 0);
        chk("arst_d_hs", d_hs, 1);
        chk("arst_d_bl", d_bl, 0);
        chk("arst_s_x", s_x, 0);
        chk("arst_s_hs", s_hs, 0);
        #2 rst_n = 1'b1;
        step;
        chk("rel_x", a_x, 1);
        chk("rel_y", a_y, 0);
        chk("rel_ls", a_ls, 0);
        chk("rel_fs", a_fs, 0);
        chk("rel_bl", a_bl, 0);
        chk("rel_d_x", d_x, 1);
        chk("rel_d_bl", d_bl, 0);
        chk("rel_s_x", s_x, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
